mem_ctrl: RTL

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 58 +++++
 rtl/mem_align.sv | 64 ++++++
 rtl/mem_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared op codes, widths, FSM encoding and helper functions
// for the MEM-stage memory controller (mem_ctrl) and its lane aligner (mem_align).
package mem_ctrl_pkg;

    localparam int unsigned MemDataWidth  = 32;
    localparam int unsigned MemAddrWidth  = 32;
    localparam int unsigned ByteSlctWidth = 4;
    localparam int unsigned OpWidth       = 4;
    localparam int unsigned CntWidth      = 4;   // holds LATENCY up to 8

    localparam logic [OpWidth-1:0] OP_NOP = 4'd0;
    localparam logic [OpWidth-1:0] OP_LB  = 4'd1;
    localparam logic [OpWidth-1:0] OP_LBU = 4'd2;
    localparam logic [OpWidth-1:0] OP_LH  = 4'd3;
    localparam logic [OpWidth-1:0] OP_LHU = 4'd4;
    localparam logic [OpWidth-1:0] OP_LW  = 4'd5;
    localparam logic [OpWidth-1:0] OP_SB  = 4'd6;
    localparam logic [OpWidth-1:0] OP_SH  = 4'd7;
    localparam logic [OpWidth-1:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Request fields still needed after acceptance (load extraction)
    typedef struct packed {
        logic [OpWidth-1:0] op;
        logic [1:0]         offset;
    } mem_lat_t;

    // Undefined op codes collapse to NOP
    function automatic logic [OpWidth-1:0] norm_op(input logic [OpWidth-1:0] op);
        return (op > OP_SW) ? OP_NOP : op;
    endfunction

    function automatic logic is_load(input logic [OpWidth-1:0] op);
        return (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic logic is_store(input logic [OpWidth-1:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic is_misaligned(input logic [OpWidth-1:0] op,
                                           input logic [1:0]         offset);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: bad = offset[0];
            OP_LW, OP_SW:         bad = (offset != 2'd0);
            default:              bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_align.sv
// mem_align: combinational big-endian byte-lane logic.
//   op, offset : normalized op code and address[1:0]
//   wdata      : right-justified store data
//   rword      : memory read word
//   sdata      : store data with lanes replicated
//   slct       : per-lane write enable (bit3 = data[31:24]); 0 for non-stores
//   ldata      : extracted and extended load result; 0 for non-loads
module mem_align
    import mem_ctrl_pkg::*;
(
    input  logic [OpWidth-1:0]       op,
    input  logic [1:0]               offset,
    input  logic [MemDataWidth-1:0]  wdata,
    input  logic [MemDataWidth-1:0]  rword,
    output logic [MemDataWidth-1:0]  sdata,
    output logic [ByteSlctWidth-1:0] slct,
    output logic [MemDataWidth-1:0]  ldata
);

    logic [7:0]  bsel;
    logic [15:0] hsel;

    // Offset 0 addresses the most significant lane
    always_comb begin
        bsel = 8'h00;
        case (offset)
            2'd0: bsel = rword[31:24];
            2'd1: bsel = rword[23:16];
            2'd2: bsel = rword[15:8];
            2'd3: bsel = rword[7:0];
            default: bsel = 8'h00;
        endcase
        hsel = offset[1] ? rword[15:0] : rword[31:16];
    end

    always_comb begin
        sdata = '0;
        slct  = '0;
        ldata = '0;
        case (op)
            OP_SB: begin
                slct  = 4'b1000 >> offset;
                sdata = {4{wdata[7:0]}};
            end
            OP_SH: begin
                slct  = offset[1] ? 4'b0011 : 4'b1100;
                sdata = {2{wdata[15:0]}};
            end
            OP_SW: begin
                slct  = 4'b1111;
                sdata = wdata;
            end
            OP_LB:  ldata = {{24{bsel[7]}}, bsel};
            OP_LBU: ldata = {24'h000000, bsel};
            OP_LH:  ldata = {{16{hsel[15]}}, hsel};
            OP_LHU: ldata = {16'h0000, hsel};
            OP_LW:  ldata = rword;
            default: begin
                sdata = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: MEM-stage memory controller, IDLE -> ACCESS (LATENCY cycles) -> RESP.
//   clk, rst        : clock, synchronous active-high reset
//   req_i, op_i     : held request and op code; addr_i, wdata_i operands
//   rdata_o, done_o : load result and one-cycle completion pulse
//   stall_o         : pipeline stall request (IDLE&req or ACCESS)
//   mem_*           : registered memory port; mem_data_i is the read word
//   adel_o, ades_o  : load/store address-error flags, valid with done_o
// Optional feature: define MEM_ADDR_EXC_EN to trap misaligned LH/LHU/LW/SH/SW.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        stall_o,
    output logic        mem_ce_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic [3:0]  mem_byte_slct_o,
    input  logic [31:0] mem_data_i,
    output logic        adel_o,
    output logic        ades_o
);

    state_e                    state;
    logic [CntWidth-1:0]       cnt;
    mem_lat_t                  lat;
    logic [OpWidth-1:0]        op_n;
    logic                      addr_exc;
    logic [OpWidth-1:0]        align_op;
    logic [1:0]                align_off;
    logic [MemDataWidth-1:0]   sdata;
    logic [ByteSlctWidth-1:0]  slct;
    logic [MemDataWidth-1:0]   ldata;

    assign op_n = norm_op(op_i);

`ifdef MEM_ADDR_EXC_EN
    assign addr_exc = is_misaligned(op_n, addr_i[1:0]);
`else
    assign addr_exc = 1'b0;
`endif

    // Aligner sees the incoming request in IDLE (store lanes) and the latched one later (load extract)
    assign align_op  = (state == ST_IDLE) ? op_n : lat.op;
    assign align_off = (state == ST_IDLE) ? addr_i[1:0] : lat.offset;

    mem_align u_align (
        .op     (align_op),
        .offset (align_off),
        .wdata  (wdata_i),
        .rword  (mem_data_i),
        .sdata  (sdata),
        .slct   (slct),
        .ldata  (ldata)
    );

    // Combinational so the stall is raised in the same cycle the request appears
    assign stall_o = ((state == ST_IDLE) && req_i) || (state == ST_ACCESS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            lat             <= '0;
            rdata_o         <= '0;
            done_o          <= 1'b0;
            mem_ce_o        <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_addr_o      <= '0;
            mem_data_o      <= '0;
            mem_byte_slct_o <= '0;
            adel_o          <= 1'b0;
            ades_o          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_o  <= 1'b0;
                    rdata_o <= '0;
                    adel_o  <= 1'b0;
                    ades_o  <= 1'b0;
                    if (req_i) begin
                        if (op_n == OP_NOP) begin
                            state  <= ST_RESP;
                            done_o <= 1'b1;
                        end else if (addr_exc) begin
                            state  <= ST_RESP;
                            done_o <= 1'b1;
                            adel_o <= is_load(op_n);
                            ades_o <= is_store(op_n);
                        end else begin
                            state           <= ST_ACCESS;
                            cnt             <= CntWidth'(LATENCY);
                            lat             <= '{op: op_n, offset: addr_i[1:0]};
                            mem_ce_o        <= 1'b1;
                            mem_we_o        <= is_store(op_n);
                            mem_addr_o      <= addr_i;
                            mem_data_o      <= sdata;
                            mem_byte_slct_o <= slct;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt == CntWidth'(1)) begin
                        state           <= ST_RESP;
                        cnt             <= '0;
                        done_o          <= 1'b1;
                        rdata_o         <= ldata;
                        mem_ce_o        <= 1'b0;
                        mem_we_o        <= 1'b0;
                        mem_addr_o      <= '0;
                        mem_data_o      <= '0;
                        mem_byte_slct_o <= '0;
                    end else begin
                        cnt <= cnt - CntWidth'(1);
                    end
                end
                ST_RESP: begin
                    state   <= ST_IDLE;
                    done_o  <= 1'b0;
                    rdata_o <= '0;
                    adel_o  <= 1'b0;
                    ades_o  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
